// File: rtl/clock_period_monitor.sv
// Measures the period and high time of a divided clock, sampled in the clk_i domain, and flags range errors and stalls.
// Optional duty-cycle check with extra duty_err_o output: define CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN.
module clock_period_monitor #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 4,
  parameter int MAX_PERIOD  = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             mon_clk_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid_o,
  output logic             err_o,
  output logic             stall_o
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
  ,
  output logic             duty_err_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   mon_s;
  logic                   rise_s;
  logic                   fall_s;
  state_e                 state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       high_cap_r;
  logic [CNT_W-1:0]       cnt_inc_s;
  logic                   meas_s;
  logic                   timeout_s;
  logic                   range_bad_s;
  logic                   err_set_s;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
  localparam logic [CNT_W+1:0] DUTY_TOL = {{(CNT_W+1){1'b0}}, 1'b1};
  logic [CNT_W+1:0] twice_high_s;
  logic [CNT_W+1:0] cnt_ext_s;
  logic [CNT_W+1:0] duty_diff_s;
  logic             duty_bad_s;
`endif

  // Synchronizer chain for the asynchronous monitored clock plus edge history
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], mon_clk_i};
      prev_r <= mon_s;
    end
  end

  // Edge detection, saturating increment and error-set conditions
  always_comb begin
    mon_s  = sync_r[SYNC_STAGES-1];
    rise_s = mon_s & ~prev_r;
    fall_s = ~mon_s & prev_r;

    if (cnt_r == CNT_SAT) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_ONE;
    end

    meas_s = (state_r == LOW) && rise_s;

    // An edge arriving in the timeout cycle still counts as progress
    if (cnt_r == TIMEOUT_C) begin
      if (state_r == HIGH) begin
        timeout_s = ~fall_s;
      end else if (state_r == LOW) begin
        timeout_s = ~rise_s;
      end else begin
        timeout_s = 1'b0;
      end
    end else begin
      timeout_s = 1'b0;
    end

    range_bad_s = (cnt_r < MIN_C) || (cnt_r > MAX_C);

`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
    twice_high_s = {1'b0, high_cap_r, 1'b0};
    cnt_ext_s    = {2'b00, cnt_r};
    if (twice_high_s >= cnt_ext_s) begin
      duty_diff_s = twice_high_s - cnt_ext_s;
    end else begin
      duty_diff_s = cnt_ext_s - twice_high_s;
    end
    duty_bad_s = duty_diff_s > DUTY_TOL;
    err_set_s  = timeout_s | (meas_s & (range_bad_s | duty_bad_s));
`else
    err_set_s  = timeout_s | (meas_s & range_bad_s);
`endif
  end

  // Measurement FSM with registered reports and sticky flags (set beats clear)
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      high_cap_r   <= {CNT_W{1'b0}};
      period_o     <= {CNT_W{1'b0}};
      high_o       <= {CNT_W{1'b0}};
      meas_valid_o <= 1'b0;
      err_o        <= 1'b0;
      stall_o      <= 1'b0;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
      duty_err_o   <= 1'b0;
`endif
    end else begin
      meas_valid_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            cnt_r   <= CNT_ONE;
            state_r <= HIGH;
          end
        end
        HIGH: begin
          cnt_r <= cnt_inc_s;
          if (fall_s) begin
            high_cap_r <= cnt_r;
            state_r    <= LOW;
          end else if (timeout_s) begin
            state_r <= IDLE;
          end
        end
        LOW: begin
          if (rise_s) begin
            period_o     <= cnt_r;
            high_o       <= high_cap_r;
            meas_valid_o <= 1'b1;
            cnt_r        <= CNT_ONE;
            state_r      <= HIGH;
          end else if (timeout_s) begin
            cnt_r   <= cnt_inc_s;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      if (err_set_s) begin
        err_o <= 1'b1;
      end else if (clear_i) begin
        err_o <= 1'b0;
      end

      if (timeout_s) begin
        stall_o <= 1'b1;
      end else if (clear_i) begin
        stall_o <= 1'b0;
      end

`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
      if (meas_s && duty_bad_s) begin
        duty_err_o <= 1'b1;
      end else if (clear_i) begin
        duty_err_o <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed self-checking bench for clock_period_monitor: measurements, range limits, stall, clear and reset.
module tb_clock_period_monitor;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic       mon_clk_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] period_o;
  logic [7:0] high_o;
  logic       meas_valid_o;
  logic       err_o;
  logic       stall_o;
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
  logic       duty_err_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int clr_at = -1;
  int n_valid;
  int first_valid;
  int last_valid;
  int stall_cyc;
  int c0;
  logic [7:0] last_period;
  logic [7:0] last_high;
  logic       last_err;

  clock_period_monitor dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .mon_clk_i    (mon_clk_i),
    .clear_i      (clear_i),
    .period_o     (period_o),
    .high_o       (high_o),
    .meas_valid_o (meas_valid_o),
    .err_o        (err_o),
    .stall_o      (stall_o)
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
    ,
    .duty_err_o   (duty_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_valid     = 0;
    first_valid = -1;
    last_valid  = -1;
    stall_cyc   = -1;
    last_period = 8'd0;
    last_high   = 8'd0;
    last_err    = 1'b0;
  endtask

  // One reference cycle: sample outputs on the falling edge, then drive the next inputs
  task automatic tick(input logic m);
    @(negedge clk_i);
    if (meas_valid_o === 1'b1) begin
      if (n_valid == 0) first_valid = cyc;
      last_valid  = cyc;
      n_valid++;
      last_period = period_o;
      last_high   = high_o;
      last_err    = err_o;
    end
    if (stall_o === 1'b1 && stall_cyc < 0) stall_cyc = cyc;
    mon_clk_i = m;
    clear_i   = (cyc == clr_at);
    cyc++;
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) tick(1'b1);
      for (int i = 0; i < l; i++) tick(1'b0);
    end
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    repeat (3) tick(1'b0);
    reset_ni = 1'b1;
    repeat (3) tick(1'b0);
    clr_stats();
  endtask

  initial begin
    clr_stats();
    // Reset values
    repeat (3) tick(1'b0);
    check("rst_period", period_o, 0);
    check("rst_high", high_o, 0);
    check("rst_valid", meas_valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_stall", stall_o, 0);
    reset_ni = 1'b1;
    repeat (3) tick(1'b0);
    clr_stats();

    // Period 10, high 5, four periods: first rise arms, three reports
    c0 = cyc;
    wave(5, 5, 4);
    repeat (3) tick(1'b0);
    check("p10_count", n_valid, 3);
    check("p10_first_cyc", first_valid, c0 + 13);
    check("p10_spacing", last_valid - first_valid, 20);
    check("p10_period", last_period, 10);
    check("p10_high", last_high, 5);
    check("p10_err", err_o, 0);

    // Odd pattern high 3 low 2
    do_reset();
    wave(3, 2, 4);
    repeat (3) tick(1'b0);
    check("p5_count", n_valid, 3);
    check("p5_period", last_period, 5);
    check("p5_high", last_high, 3);
    check("p5_err", err_o, 0);
`ifdef CLOCK_PERIOD_MONITOR_DUTY_CHECK_EN
    check("p5_duty_err", duty_err_o, 0);
`endif

    // Period 3 is below the minimum, then clear
    do_reset();
    wave(2, 1, 2);
    repeat (3) tick(1'b0);
    check("p3_count", n_valid, 1);
    check("p3_period", last_period, 3);
    check("p3_err_at_valid", last_err, 1);
    clr_at = cyc;
    tick(1'b0);
    tick(1'b0);
    clr_at = -1;
    check("p3_cleared", err_o, 0);

    // Period 16 is the inclusive maximum
    do_reset();
    wave(8, 8, 2);
    repeat (3) tick(1'b0);
    check("p16_period", last_period, 16);
    check("p16_high", last_high, 8);
    check("p16_err", err_o, 0);

    // Period 17 is out of range
    do_reset();
    wave(9, 8, 2);
    repeat (3) tick(1'b0);
    check("p17_period", last_period, 17);
    check("p17_err", err_o, 1);

    // Clear collides with an out-of-range measurement: set wins
    do_reset();
    c0 = cyc;
    clr_at = c0 + 5;
    wave(2, 1, 2);
    repeat (3) tick(1'b0);
    clr_at = -1;
    check("coll_count", n_valid, 1);
    check("coll_err_at_valid", last_err, 1);
    check("coll_err_after", err_o, 1);

    // Stuck-high clock
    do_reset();
    c0 = cyc;
    repeat (70) tick(1'b1);
    check("stuck_stall_cyc", stall_cyc, c0 + 67);
    check("stuck_stall", stall_o, 1);
    check("stuck_err", err_o, 1);
    check("stuck_no_valid", n_valid, 0);
    repeat (3) tick(1'b0);
    clr_stats();
    wave(5, 5, 3);
    repeat (3) tick(1'b0);
    check("recover_count", n_valid, 2);
    check("recover_period", last_period, 10);
    check("recover_stall_sticky", stall_o, 1);
    clr_at = cyc;
    tick(1'b0);
    tick(1'b0);
    clr_at = -1;
    check("stall_cleared", stall_o, 0);

    // Reset asserted in the HIGH state
    do_reset();
    wave(5, 5, 2);
    check("mid_pre_period", period_o, 10);
    repeat (4) tick(1'b1);
    reset_ni = 1'b0;
    #1;
    check("mid_rst_period", period_o, 0);
    check("mid_rst_high", high_o, 0);
    check("mid_rst_err", err_o, 0);
    mon_clk_i = 1'b0;
    repeat (2) tick(1'b0);
    reset_ni = 1'b1;
    repeat (3) tick(1'b0);
    clr_stats();
    c0 = cyc;
    wave(5, 5, 2);
    repeat (3) tick(1'b0);
    check("mid_after_count", n_valid, 1);
    check("mid_after_first", first_valid, c0 + 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
